dump_sequencer: RTL and testbench

DUMP_SEQUENCER -- requirements
Module: dump_sequencer

---
 rtl/dump_seq_pkg.sv | 27 ++
 rtl/dump_addr_gen.sv | 26 ++
 rtl/dump_sequencer.sv | 126 ++++++++++++
 tb/tb_dump_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dump_seq_pkg.sv
// Shared types and address map constants for the per-channel state dump sequencer.
package dump_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StLatch,
    StWrite,
    StDone
  } state_e;

  localparam int unsigned ChW      = 5;
  localparam int unsigned WordW    = 5;
  localparam int unsigned AccW     = 4;
  localparam int unsigned MemAddrW = ChW + WordW;

  localparam logic [WordW-1:0] FirstFixedAddr = 5'd6;
  localparam logic [WordW-1:0] LastFixedAddr  = 5'd15;
  localparam logic [WordW-1:0] SkipAddr       = 5'd14;
  localparam logic [WordW-1:0] AccBaseAddr    = 5'd16;

  // Address of the final accumulator word; only meaningful for n >= 1.
  function automatic logic [WordW-1:0] acc_last_addr(input logic [AccW-1:0] n);
    return AccBaseAddr + WordW'(n) - 5'd1;
  endfunction

endpackage

// File: rtl/dump_addr_gen.sv
// Next word address and last-word flag for the dump walk: 6..13, 15, then 16..16+n-1.
module dump_addr_gen
  import dump_seq_pkg::*;
(
  input  logic [WordW-1:0] cur_addr,
  input  logic [AccW-1:0]  acc_words,
  output logic [WordW-1:0] next_addr,
  output logic             last_word
);

  always_comb begin
    next_addr = cur_addr + 5'd1;
    if (cur_addr == SkipAddr - 5'd1) begin
      next_addr = LastFixedAddr;
    end
  end

  always_comb begin
    if (acc_words == '0) begin
      last_word = (cur_addr == LastFixedAddr);
    end else begin
      last_word = (cur_addr == acc_last_addr(acc_words));
    end
  end

endmodule

// File: rtl/dump_sequencer.sv
// Walks a channel's state words through the state mux and writes each one to memory,
// one word at a time, with a request/ack/done handshake to the requester.
module dump_sequencer
  import dump_seq_pkg::*;
#(
  parameter int unsigned ACC_MAX = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dump_req,
  input  logic [ChW-1:0]      dump_ch,
  input  logic [AccW-1:0]     acc_words,
  output logic                dump_ack,
  output logic                dump_busy,
  output logic                dump_done,
  output logic [WordW-1:0]    state_addr,
  input  logic [31:0]         state_d4wt,
  output logic                mem_we,
  output logic [MemAddrW-1:0] mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic                mem_ready
);

  localparam int unsigned AccMaxEff = (ACC_MAX > 15) ? 15 : ACC_MAX;
  localparam logic [AccW-1:0] AccMax = AccW'(AccMaxEff);

  state_e state_q, state_d;

  logic [ChW-1:0]      ch_q, ch_d;
  logic [AccW-1:0]     acc_q, acc_d;
  logic [WordW-1:0]    state_addr_d;
  logic                mem_we_d;
  logic [MemAddrW-1:0] mem_addr_d;
  logic [31:0]         mem_wdata_d;
  logic                dump_ack_d, dump_busy_d, dump_done_d;

  logic [WordW-1:0] next_addr;
  logic             last_word;

  dump_addr_gen u_addr_gen (
    .cur_addr  (state_addr),
    .acc_words (acc_q),
    .next_addr (next_addr),
    .last_word (last_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ch_q       <= '0;
      acc_q      <= '0;
      state_addr <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      dump_ack   <= 1'b0;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      acc_q      <= acc_d;
      state_addr <= state_addr_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      dump_ack   <= dump_ack_d;
      dump_busy  <= dump_busy_d;
      dump_done  <= dump_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (dump_req) state_d = StIssue;
      StIssue: state_d = StLatch;
      StLatch: state_d = StWrite;
      StWrite: if (mem_ready) state_d = last_word ? StDone : StIssue;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ch_d         = ch_q;
    acc_d        = acc_q;
    state_addr_d = state_addr;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    dump_ack_d   = 1'b0;
    dump_busy_d  = dump_busy;
    dump_done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dump_req) begin
          ch_d         = dump_ch;
          acc_d        = (acc_words > AccMax) ? AccMax : acc_words;
          state_addr_d = FirstFixedAddr;
          dump_ack_d   = 1'b1;
          dump_busy_d  = 1'b1;
        end
      end
      StLatch: begin
        // Mux data is registered, so it is valid here, one cycle after ISSUE.
        mem_wdata_d = state_d4wt;
        mem_addr_d  = {ch_q, state_addr};
        mem_we_d    = 1'b1;
      end
      StWrite: begin
        if (mem_ready) begin
          mem_we_d = 1'b0;
          if (last_word) begin
            dump_done_d = 1'b1;
          end else begin
            state_addr_d = next_addr;
          end
        end
      end
      StDone: dump_busy_d = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dump_sequencer.sv
// Self-checking bench for dump_sequencer: write scoreboard, vector table and corner sequences.
module tb_dump_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dump_req = 1'b0;
  logic [4:0]  dump_ch = '0;
  logic [3:0]  acc_words = '0;
  logic        dump_ack, dump_busy, dump_done;
  logic [4:0]  state_addr;
  logic [31:0] state_d4wt = '0;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b1;

  dump_sequencer #(.ACC_MAX(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .dump_req   (dump_req),
    .dump_ch    (dump_ch),
    .acc_words  (acc_words),
    .dump_ack   (dump_ack),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done),
    .state_addr (state_addr),
    .state_d4wt (state_d4wt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [4:0] ch;
    logic [3:0] acc;
    int         sidx;
    int         slen;
    int         nwr;
    int         lat;
    logic [9:0] last;
  } vec_t;

  wr_t         exp_q[$];
  int          n_pass = 0, n_total = 0;
  int          cyc = 0;
  int          wr_idx = 0;
  int          stall_idx = -1, stall_len = 0, stall_cnt = 0;
  int          done_cnt = 0, ack_cnt = 0, we_cnt = 0;
  logic [9:0]  last_addr = '0, held_addr = '0;
  logic [31:0] held_data = '0;
  logic [31:0] salt = 32'h1234_5678;

  function automatic logic [31:0] mux_data(input logic [4:0] a);
    return salt ^ ({27'd0, a} * 32'h9E37_79B9);
  endfunction

  // Registered state mux model: data follows state_addr by one clock.
  always @(posedge clk) state_d4wt <= mux_data(state_addr);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic push_expected(input logic [4:0] ch, input logic [3:0] n);
    wr_t w;
    for (int a = 6; a <= 13; a++) begin
      w.addr = {ch, 5'(a)};
      w.data = mux_data(5'(a));
      exp_q.push_back(w);
    end
    w.addr = {ch, 5'd15};
    w.data = mux_data(5'd15);
    exp_q.push_back(w);
    for (int i = 0; i < int'(n); i++) begin
      w.addr = {ch, 5'(16 + i)};
      w.data = mux_data(5'(16 + i));
      exp_q.push_back(w);
    end
  endtask

  // mem_ready is set up for the coming edge; a write seen here with ready high is accepted there.
  always @(negedge clk) begin
    if (rst) begin
      mem_ready = 1'b1;
    end else begin
      if (dump_ack) ack_cnt++;
      if (dump_done) done_cnt++;
      if (mem_we) we_cnt++;
      if (mem_we && stall_idx >= 0 && wr_idx == stall_idx && stall_cnt < stall_len) begin
        if (stall_cnt == 0) begin
          held_addr = mem_addr;
          held_data = mem_wdata;
        end else begin
          check("stall_hold", {mem_we, mem_addr, mem_wdata}, {1'b1, held_addr, held_data});
        end
        stall_cnt++;
        mem_ready = 1'b0;
      end else begin
        mem_ready = 1'b1;
      end
      if (mem_we && mem_ready) begin
        if (wr_idx == stall_idx && stall_cnt > 0)
          check("stall_hold_accept", {mem_addr, mem_wdata}, {held_addr, held_data});
        check("write_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          wr_t w;
          w = exp_q.pop_front();
          check("wr_addr", mem_addr, w.addr);
          check("wr_data", mem_wdata, w.data);
        end
        wr_idx++;
        last_addr = mem_addr;
      end
    end
  end

  task automatic start_req(input logic [4:0] ch, input logic [3:0] acc, output int ack_cyc);
    bit ok;
    push_expected(ch, acc);
    @(negedge clk);
    dump_req  = 1'b1;
    dump_ch   = ch;
    acc_words = acc;
    ok = 0;
    ack_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (dump_ack) begin
        ok = 1;
        ack_cyc = cyc;
        break;
      end
    end
    check("ack_seen", 64'(ok), 64'd1);
    if (ok) check("busy_at_ack", 64'(dump_busy), 64'd1);
  endtask

  task automatic wait_done(output int done_cyc);
    bit ok;
    ok = 0;
    done_cyc = -1;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (dump_done) begin
        ok = 1;
        done_cyc = cyc;
        break;
      end
    end
    check("done_seen", 64'(ok), 64'd1);
    if (ok) check("busy_at_done", 64'(dump_busy), 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int a, d;
    exp_q.delete();
    salt      = $urandom;
    wr_idx    = 0;
    stall_idx = v.sidx;
    stall_len = v.slen;
    stall_cnt = 0;
    start_req(v.ch, v.acc, a);
    @(negedge clk);
    dump_req = 1'b0;
    wait_done(d);
    check("latency", 64'(d - a), 64'(v.lat));
    check("write_count", 64'(wr_idx), 64'(v.nwr));
    check("last_addr", last_addr, v.last);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    check("idle_after_done", {dump_busy, dump_done, mem_we}, 3'b000);
    stall_idx = -1;
  endtask

  vec_t vecs[6];

  initial begin
    int a, d, a2, d2, base_ack, base_done, base_we;

    vecs[0] = '{5'd3,  4'd4,  -1, 0, 13, 39, 10'h073};
    vecs[1] = '{5'd31, 4'd0,  -1, 0,  9, 27, 10'h3EF};
    vecs[2] = '{5'd3,  4'd4,   2, 5, 13, 44, 10'h073};
    vecs[3] = '{5'd5,  4'd15, -1, 0, 24, 72, 10'h0BE};
    vecs[4] = '{5'd0,  4'd1,   0, 3, 10, 33, 10'h010};
    vecs[5] = '{5'd18, 4'd7,   8, 2, 16, 50, 10'h256};

    // Request held high through reset release.
    dump_req  = 1'b1;
    dump_ch   = 5'd1;
    acc_words = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {state_addr, mem_we, mem_addr, mem_wdata, dump_ack, dump_busy, dump_done},
          '0);
    push_expected(5'd1, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ack_at_release", 64'(dump_ack), 64'd1);
    a = cyc;
    @(negedge clk);
    dump_req = 1'b0;
    wait_done(d);
    check("release_latency", 64'(d - a), 64'd27);
    check("release_writes", 64'(wr_idx), 64'd9);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Second request held while busy: no ack until after done, no interleave.
    exp_q.delete();
    wr_idx   = 0;
    base_ack = ack_cnt;
    start_req(5'd3, 4'd2, a);
    push_expected(5'd7, 4'd1);
    @(negedge clk);
    dump_ch   = 5'd7;
    acc_words = 4'd1;
    wait_done(d);
    check("busy_latency", 64'(d - a), 64'd33);
    check("no_ack_while_busy", 64'(ack_cnt - base_ack), 64'd1);
    a2 = -1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (dump_ack) begin
        a2 = cyc;
        break;
      end
    end
    check("second_ack_gap", 64'(a2 - d), 64'd2);
    @(negedge clk);
    dump_req = 1'b0;
    wait_done(d2);
    check("second_latency", 64'(d2 - a2), 64'd30);
    check("second_writes", 64'(wr_idx), 64'd21);
    check("second_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset while stalled in WRITE of address 12.
    exp_q.delete();
    wr_idx    = 0;
    stall_idx = 6;
    stall_len = 1000;
    stall_cnt = 0;
    start_req(5'd4, 4'd4, a);
    @(negedge clk);
    dump_req = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (stall_cnt >= 3) break;
    end
    check("reached_stall", 64'(stall_cnt >= 3), 64'd1);
    check("stall_addr", mem_addr, 10'h08C);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_mid", {state_addr, mem_we, mem_addr, mem_wdata, dump_ack, dump_busy, dump_done},
          '0);
    exp_q.delete();
    stall_idx = -1;
    base_done = done_cnt;
    base_we   = we_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("no_done_after_reset", 64'(done_cnt - base_done), 64'd0);
    check("no_we_after_reset", 64'(we_cnt - base_we), 64'd0);
    run_vec('{5'd9, 4'd3, -1, 0, 12, 36, 10'h132});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
